// File: rtl/iwdg_key_writer_if.sv
// iwdg_key_writer_if
// Command and register-write signals between the core-side control logic
// and the IWDG key writer.
//   master : core side, drives the command request and the core heartbeat.
//   slave  : key writer, answers with ready, register writes and status.
// Command fields : i_cmd_valid, i_cmd[1:0], i_pr[2:0], i_rlr[11:0], i_core_alive
// Write/status   : o_cmd_ready, o_kr[15:0]/o_kr_we, o_pr[2:0]/o_pr_we,
//                  o_rlr[11:0]/o_rlr_we, o_started, o_done, o_err
interface iwdg_key_writer_if;
  logic        i_cmd_valid;
  logic [1:0]  i_cmd;
  logic [2:0]  i_pr;
  logic [11:0] i_rlr;
  logic        i_core_alive;
  logic        o_cmd_ready;
  logic [15:0] o_kr;
  logic        o_kr_we;
  logic [2:0]  o_pr;
  logic        o_pr_we;
  logic [11:0] o_rlr;
  logic        o_rlr_we;
  logic        o_started;
  logic        o_done;
  logic        o_err;

  modport master (
    output i_cmd_valid, i_cmd, i_pr, i_rlr, i_core_alive,
    input  o_cmd_ready, o_kr, o_kr_we, o_pr, o_pr_we, o_rlr, o_rlr_we,
           o_started, o_done, o_err
  );

  modport slave (
    input  i_cmd_valid, i_cmd, i_pr, i_rlr, i_core_alive,
    output o_cmd_ready, o_kr, o_kr_we, o_pr, o_pr_we, o_rlr, o_rlr_we,
           o_started, o_done, o_err
  );
endinterface

// File: rtl/iwdg_key_writer.sv
// iwdg_key_writer
// Turns single core commands (START, REFRESH, CONFIG) into ordered, strobed
// writes of the IWDG key, prescaler and reload registers.
// Ports:
//   CLOCK  : single clock, rising edge
//   i_arst : asynchronous active-high reset
//   bus    : iwdg_key_writer_if.slave (command handshake, register writes, status)
// Parameters:
//   GAP            : idle cycles between consecutive strobes of one sequence (0..15)
//   REFRESH_PERIOD : auto-refresh interval in clock cycles (2..65535)
// Optional feature: define AUTO_REFRESH_EN to add the periodic auto-refresh
// counter and pending flag; without it, AAAA is written only on command.
module iwdg_key_writer #(
  parameter int GAP            = 1,
  parameter int REFRESH_PERIOD = 1000
) (
  input  logic             CLOCK,
  input  logic             i_arst,
  iwdg_key_writer_if.slave bus
);
  localparam logic [15:0] KEY_START   = 16'hCCCC;
  localparam logic [15:0] KEY_REFRESH = 16'hAAAA;
  localparam logic [15:0] KEY_UNLOCK  = 16'h5555;
  localparam logic [3:0]  GAP_LAST    = 4'(GAP - 1);

  typedef enum logic [2:0] {S_IDLE, S_UNLOCK, S_WR_PR, S_WR_RLR, S_KEY, S_WAIT} state_t;

  state_t      state_reg, state_next, ret_reg, ret_next;
  logic [3:0]  gap_cnt_reg, gap_cnt_next;
  logic [2:0]  pr_lat_reg, pr_lat_next;
  logic [11:0] rlr_lat_reg, rlr_lat_next;
  logic        auto_seq_reg, auto_seq_next;
  logic [15:0] kr_reg, kr_next;
  logic        kr_we_reg, kr_we_next;
  logic [2:0]  pr_reg, pr_next;
  logic        pr_we_reg, pr_we_next;
  logic [11:0] rlr_reg, rlr_next;
  logic        rlr_we_reg, rlr_we_next;
  logic        started_reg, started_next;
  logic        done_reg, done_next;
  logic        err_reg, err_next;
  logic        refresh_strobe;   // an AAAA key write is launched at this edge
  logic        pending;          // auto-refresh waiting to be issued
  logic        cmd_ready, accept;
  logic        step_en, enter_en;
  state_t      step_target, enter_target;

  assign cmd_ready = (state_reg == S_IDLE) && !pending;
  assign accept    = bus.i_cmd_valid && cmd_ready;

  // All outputs are registered: the strobe for a write state is launched on
  // the same edge that enters that state, so it is high for exactly the cycle
  // the FSM spends there.
  always_comb begin
    state_next     = state_reg;
    ret_next       = ret_reg;
    gap_cnt_next   = gap_cnt_reg;
    pr_lat_next    = pr_lat_reg;
    rlr_lat_next   = rlr_lat_reg;
    auto_seq_next  = auto_seq_reg;
    kr_next        = kr_reg;
    kr_we_next     = 1'b0;
    pr_next        = pr_reg;
    pr_we_next     = 1'b0;
    rlr_next       = rlr_reg;
    rlr_we_next    = 1'b0;
    started_next   = started_reg;
    done_next      = 1'b0;
    err_next       = 1'b0;
    refresh_strobe = 1'b0;
    step_en        = 1'b0;
    step_target    = S_IDLE;
    enter_en       = 1'b0;
    enter_target   = S_IDLE;

    case (state_reg)
      S_IDLE: begin
        if (pending) begin
          state_next     = S_KEY;
          kr_next        = KEY_REFRESH;
          kr_we_next     = 1'b1;
          refresh_strobe = 1'b1;
          auto_seq_next  = 1'b1;
        end else if (accept) begin
          pr_lat_next   = bus.i_pr;
          rlr_lat_next  = bus.i_rlr;
          auto_seq_next = 1'b0;
          case (bus.i_cmd)
            2'b00: begin
              state_next   = S_KEY;
              kr_next      = KEY_START;
              kr_we_next   = 1'b1;
              started_next = 1'b1;
            end
            2'b01: begin
              if (started_reg) begin
                state_next     = S_KEY;
                kr_next        = KEY_REFRESH;
                kr_we_next     = 1'b1;
                refresh_strobe = 1'b1;
              end else begin
                err_next = 1'b1;
              end
            end
            2'b10: begin
              state_next = S_UNLOCK;
              kr_next    = KEY_UNLOCK;
              kr_we_next = 1'b1;
            end
            default: err_next = 1'b1;
          endcase
        end
      end
      S_UNLOCK: begin step_en = 1'b1; step_target = S_WR_PR;  end
      S_WR_PR:  begin step_en = 1'b1; step_target = S_WR_RLR; end
      S_WR_RLR: begin step_en = 1'b1; step_target = S_KEY;    end
      S_KEY: begin
        state_next = S_IDLE;
        done_next  = !auto_seq_reg;  // automatic refreshes complete silently
      end
      S_WAIT: begin
        if (gap_cnt_reg == 4'd0) begin
          enter_en     = 1'b1;
          enter_target = ret_reg;
        end else begin
          gap_cnt_next = gap_cnt_reg - 4'd1;
        end
      end
      default: state_next = S_IDLE;
    endcase

    // Leaving a CONFIG write state: go through WAIT unless no gap is wanted.
    if (step_en) begin
      if (GAP == 0) begin
        enter_en     = 1'b1;
        enter_target = step_target;
      end else begin
        state_next   = S_WAIT;
        ret_next     = step_target;
        gap_cnt_next = GAP_LAST;
      end
    end

    if (enter_en) begin
      state_next = enter_target;
      case (enter_target)
        S_WR_PR: begin
          pr_next    = pr_lat_reg;
          pr_we_next = 1'b1;
        end
        S_WR_RLR: begin
          rlr_next    = rlr_lat_reg;
          rlr_we_next = 1'b1;
        end
        default: begin
          kr_next        = KEY_REFRESH;
          kr_we_next     = 1'b1;
          refresh_strobe = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge CLOCK or posedge i_arst) begin
    if (i_arst) begin
      state_reg    <= S_IDLE;
      ret_reg      <= S_IDLE;
      gap_cnt_reg  <= '0;
      pr_lat_reg   <= '0;
      rlr_lat_reg  <= '0;
      auto_seq_reg <= 1'b0;
      kr_reg       <= '0;
      kr_we_reg    <= 1'b0;
      pr_reg       <= '0;
      pr_we_reg    <= 1'b0;
      rlr_reg      <= '0;
      rlr_we_reg   <= 1'b0;
      started_reg  <= 1'b0;
      done_reg     <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      ret_reg      <= ret_next;
      gap_cnt_reg  <= gap_cnt_next;
      pr_lat_reg   <= pr_lat_next;
      rlr_lat_reg  <= rlr_lat_next;
      auto_seq_reg <= auto_seq_next;
      kr_reg       <= kr_next;
      kr_we_reg    <= kr_we_next;
      pr_reg       <= pr_next;
      pr_we_reg    <= pr_we_next;
      rlr_reg      <= rlr_next;
      rlr_we_reg   <= rlr_we_next;
      started_reg  <= started_next;
      done_reg     <= done_next;
      err_reg      <= err_next;
    end
  end

`ifdef AUTO_REFRESH_EN
  localparam logic [15:0] CNT_LAST = 16'(REFRESH_PERIOD - 1);
  logic [15:0] refresh_cnt_reg, refresh_cnt_next;
  logic        pending_reg, pending_next;

  // The counter is zero during the cycle of every AAAA strobe, so with the
  // core alive the strobes repeat every REFRESH_PERIOD+1 cycles. A dead core
  // leaves the counter parked at its last value and nothing is requested.
  // Any AAAA write also satisfies an outstanding request.
  always_comb begin
    refresh_cnt_next = refresh_cnt_reg;
    pending_next     = pending_reg;
    if (refresh_strobe) begin
      refresh_cnt_next = '0;
      pending_next     = 1'b0;
    end else if (started_reg) begin
      if (refresh_cnt_reg != CNT_LAST) begin
        refresh_cnt_next = refresh_cnt_reg + 16'd1;
      end else if (bus.i_core_alive) begin
        pending_next = 1'b1;
      end
    end
  end

  always_ff @(posedge CLOCK or posedge i_arst) begin
    if (i_arst) begin
      refresh_cnt_reg <= '0;
      pending_reg     <= 1'b0;
    end else begin
      refresh_cnt_reg <= refresh_cnt_next;
      pending_reg     <= pending_next;
    end
  end

  assign pending = pending_reg;
`else
  logic [16:0] unused_auto_cfg;
  assign unused_auto_cfg = {bus.i_core_alive, 16'(REFRESH_PERIOD)};
  assign pending = 1'b0;
`endif

  assign bus.o_cmd_ready = cmd_ready;
  assign bus.o_kr        = kr_reg;
  assign bus.o_kr_we     = kr_we_reg;
  assign bus.o_pr        = pr_reg;
  assign bus.o_pr_we     = pr_we_reg;
  assign bus.o_rlr       = rlr_reg;
  assign bus.o_rlr_we    = rlr_we_reg;
  assign bus.o_started   = started_reg;
  assign bus.o_done      = done_reg;
  assign bus.o_err       = err_reg;
endmodule
